rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one resource (bus, port, memory bank) among four masters. It chooses the winner's 2-bit index and drives a one-hot grant vector, the same encoding a 2-to-4 decoder produces. Each grant is held while the winner keeps requesting, and it is pre-empted after a bounded hold time if others are waiting. The block sits between the requesters and the shared resource; `gnt_idx` can steer the resource's select lines directly.

## Interface
- `MAX_HOLD`, default 8: maximum grant cycles for one owner while any other requester is pending. Legal range is 1..255.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  4  request lines; bit i belongs to requester i; level-sensitive.
- `gnt`  out  4  one-hot grant, registered; `4'b0000` when idle.
- `gnt_idx`  out  2  binary index of the current owner, registered; holds its last value when idle.
- `gnt_valid`  out  1  registered; high exactly when `gnt` != 0.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Priority pointer `ptr[1:0]`.
  - Hold counter `cnt`, $clog2(MAX_HOLD+1) bits wide.
- Reset values: state=IDLE, `ptr`=0, `cnt`=0, `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0.
- `gnt` always equals the decode of `gnt_idx`, gated by `gnt_valid`.
- **IDLE:**
  - If `req`==0, stay in IDLE.
  - Otherwise search in order ptr, ptr+1, ptr+2, ptr+3 (all mod 4) and take the first set bit as winner w.
  - Next cycle: state=GRANT, `gnt_idx`=w, `gnt_valid`=1, `cnt`=1, `ptr`=w+1 mod 4 (3 wraps to 0).
- **GRANT, owner o:**
  - If `req[o]`==0: go to IDLE; `gnt_valid` and `gnt` clear next cycle.
  - Else if `cnt` >= MAX_HOLD and (`req` & ~onehot(o)) != 0: forced release, go to IDLE.
  - Otherwise stay in GRANT; `cnt` increments and saturates at MAX_HOLD.
- Every release, voluntary or forced, passes through IDLE for at least one cycle. This bus-turnaround bubble is guaranteed: `gnt`==0 for exactly one cycle before the next grant, provided any request is pending.
- A sole requester holds the grant indefinitely. Once `cnt` saturates, a newly arriving competitor pre-empts on the cycle after it is first sampled.
- Requests arriving or dropping while in GRANT have no effect on the other requesters' priority order; `ptr` changes only when a grant is issued.
- No combinational path from `req` to any output.

## Timing
- Latency from `req` rising in IDLE to grant: 1 cycle. `req` sampled at edge N gives `gnt` valid after edge N.
- Release latency: `req[o]` low at edge N gives `gnt`=0 after edge N.
- Under full contention the owner holds `gnt` for exactly MAX_HOLD cycles, followed by 1 idle cycle. Per-requester period is 4*(MAX_HOLD+1) cycles.
- Simultaneous drop of `req[o]` and `cnt` reaching MAX_HOLD is treated as a voluntary release; the resulting behaviour is identical.
- Reset asserted mid-grant: `gnt` reads 0000 after that edge and `ptr` returns to 0. After reset falls, the first grant goes to the lowest set `req` bit.
- Reset dominates all other inputs on the same edge.

## Test plan
- Reset, `req`=0000 for 5 cycles: `gnt`=0000, `gnt_valid`=0, `gnt_idx`=00 throughout.
- After reset, `req`=0100 held 20 cycles with MAX_HOLD=8:
  - `gnt`=0100 and `gnt_idx`=10 from cycle 1, held all 20 cycles with no forced release.
  - Drop `req`; `gnt`=0000 the next cycle.
- `req`=1111 constant with MAX_HOLD=2:
  - Grant sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000, then back to 0001.
  - Confirms rotation, wrap from 3 to 0, and the one-cycle bubble.
- Pointer fairness:
  - Grant requester 3 once, then release with `req`=1001 applied.
  - Next winner is 0 (wrap), not 3, even though 3 is still requesting.
- Pre-emption check, MAX_HOLD=4:
  - Requester 1 holds alone for 10 cycles; `req[2]` rises at cycle 10.
  - `gnt`=0000 at cycle 11, `gnt`=0100 at cycle 12.
- Reset mid-grant:
  - With `req`=1010 and requester 3 granted, pulse `reset` for 1 cycle, keeping `req`=1010.
  - `gnt`=0000 during reset; the first grant after reset is 0010 (`ptr`=0, so requester 1 wins).

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if
// Groups the request/grant signals shared between four requesters and the
// round-robin arbiter.
//   req        requester -> arbiter, one level-sensitive request per master
//   gnt        arbiter -> requesters, one-hot grant (0000 when idle)
//   gnt_idx    arbiter -> resource, binary index of the current owner
//   gnt_valid  arbiter -> resource, high exactly when gnt != 0
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Four-requester round-robin arbiter with a bounded hold time. A winner keeps
// the grant while it requests; once it has held for MAX_HOLD cycles and
// someone else is waiting, it is pre-empted. Every release inserts one idle
// (bus-turnaround) cycle before the next grant.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    rr_arbiter4_if.slave: req in, gnt / gnt_idx / gnt_valid out
// Parameter:
//   MAX_HOLD  maximum grant cycles while another requester is pending (1..255)
// All outputs come straight from registers; there is no path from req to any
// output within a cycle.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  rr_arbiter4_if.slave bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic            valid_reg, valid_next;
  logic [3:0]      gnt_reg, gnt_next;

  // Candidate search order starting at the priority pointer: ptr, ptr+1, ...
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;
  logic [1:0] win_idx;

  // One-hot forms of the current owner and of the next owner.
  logic [3:0] owner_oh;
  logic [3:0] next_oh;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_search
      assign cand_idx[gi] = ptr_reg + 2'(gi);
      assign cand_hit[gi] = bus.req[cand_idx[gi]];
    end
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign owner_oh[gi] = (idx_reg  == 2'(gi));
      assign next_oh[gi]  = (idx_next == 2'(gi));
    end
  endgenerate

  // First set candidate in rotated order wins; scanning from the far end
  // lets the nearest hit overwrite the others.
  always_comb begin
    win_idx = cand_idx[0];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_idx = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;

    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next = GRANT;
          idx_next   = win_idx;
          valid_next = 1'b1;
          cnt_next   = CW'(1);
          // Pointer only moves when a grant is issued.
          ptr_next   = win_idx + 2'd1;
        end
      end
      GRANT: begin
        if (!bus.req[idx_reg]) begin
          // Voluntary release takes precedence; same outcome as forced.
          state_next = IDLE;
          valid_next = 1'b0;
        end else if ((cnt_reg >= CW'(MAX_HOLD)) && |(bus.req & ~owner_oh)) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else if (cnt_reg < CW'(MAX_HOLD)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase

    gnt_next = valid_next ? next_oh : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      valid_reg <= 1'b0;
      gnt_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      gnt_reg   <= gnt_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = idx_reg;
  assign bus.gnt_valid = valid_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4
// Scoreboard bench for rr_arbiter4. Three instances (MAX_HOLD = 8, 2, 4) share
// clock and reset. Stimulus drives req just after a rising edge and queues the
// output expected after the following edge, tagged with that edge number; a
// monitor on the falling edge pops and compares every entry due that cycle.
module tb_rr_arbiter4;

  logic clk;
  logic reset;
  int   cycle;

  rr_arbiter4_if bus8 ();
  rr_arbiter4_if bus2 ();
  rr_arbiter4_if bus4 ();

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  rr_arbiter4 #(.MAX_HOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  rr_arbiter4 #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  typedef struct {
    int         cyc;
    int         d;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  bit   stim_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Drivers and expectation helpers.
  task automatic set_req(input int d, input logic [3:0] r);
    case (d)
      8:       bus8.req = r;
      2:       bus2.req = r;
      default: bus4.req = r;
    endcase
  endtask

  task automatic expect_next(input int d, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input string name);
    exp_t e;
    e.cyc  = cycle + 1;
    e.d    = d;
    e.g    = g;
    e.idx  = idx;
    e.v    = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due on the current cycle.
  initial begin
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    exp_t       e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e = exp_q.pop_front();
        case (e.d)
          8:       begin ag = bus8.gnt; ai = bus8.gnt_idx; av = bus8.gnt_valid; end
          2:       begin ag = bus2.gnt; ai = bus2.gnt_idx; av = bus2.gnt_valid; end
          default: begin ag = bus4.gnt; ai = bus4.gnt_idx; av = bus4.gnt_valid; end
        endcase
        n_checks++;
        if (e.cyc != cycle) begin
          $display("FAIL %s dut%0d: expectation for cycle %0d missed (now %0d)",
                   e.name, e.d, e.cyc, cycle);
        end else if (ag !== e.g || ai !== e.idx || av !== e.v) begin
          $display("FAIL %s dut%0d cyc %0d: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                   e.name, e.d, cycle, ag, ai, av, e.g, e.idx, e.v);
        end else begin
          n_pass++;
          $display("ok   %s dut%0d cyc %0d: gnt=%b idx=%0d valid=%b",
                   e.name, e.d, cycle, ag, ai, av);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Full-contention pattern for MAX_HOLD=2 starting with ptr=0.
  logic [3:0] rot_g [13];
  logic [1:0] rot_i [13];
  logic       rot_v [13];

  initial begin
    rot_g = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
              4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    rot_i = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
              2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    rot_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    cycle     = 0;
    n_checks  = 0;
    n_pass    = 0;
    stim_done = 1'b0;
    reset     = 1'b1;
    bus8.req  = 4'b0000;
    bus2.req  = 4'b0000;
    bus4.req  = 4'b0000;
    tick();

    // Reset with no requests: all outputs quiet.
    for (int i = 0; i < 5; i++) begin
      expect_next(8, 4'b0000, 2'd0, 1'b0, "reset8");
      expect_next(2, 4'b0000, 2'd0, 1'b0, "reset2");
      expect_next(4, 4'b0000, 2'd0, 1'b0, "reset4");
      tick();
    end
    reset = 1'b0;

    // Sole requester 2 holds for 20 cycles without a forced release.
    set_req(8, 4'b0100);
    for (int i = 0; i < 20; i++) begin
      expect_next(8, 4'b0100, 2'd2, 1'b1, "sole_hold");
      tick();
    end
    set_req(8, 4'b0000);
    expect_next(8, 4'b0000, 2'd2, 1'b0, "sole_drop");
    tick();

    // Full contention, MAX_HOLD=2: rotation, wrap and one-cycle bubble.
    set_req(2, 4'b1111);
    for (int i = 0; i < 13; i++) begin
      expect_next(2, rot_g[i], rot_i[i], rot_v[i], "rotate");
      tick();
    end
    set_req(2, 4'b0000);
    expect_next(2, 4'b0000, 2'd0, 1'b0, "rotate_end");
    tick();

    // Pointer fairness: ptr=1, grant 3, then 1001 forces release to 0.
    set_req(2, 4'b1000);
    expect_next(2, 4'b1000, 2'd3, 1'b1, "fair_g3");
    tick();
    set_req(2, 4'b1001);
    expect_next(2, 4'b1000, 2'd3, 1'b1, "fair_hold");
    tick();
    expect_next(2, 4'b0000, 2'd3, 1'b0, "fair_bubble");
    tick();
    expect_next(2, 4'b0001, 2'd0, 1'b1, "fair_wrap0");
    tick();
    set_req(2, 4'b0000);
    expect_next(2, 4'b0000, 2'd0, 1'b0, "fair_end");
    tick();

    // Pre-emption, MAX_HOLD=4: requester 1 alone for 10 cycles, then 2 arrives.
    set_req(4, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      expect_next(4, 4'b0010, 2'd1, 1'b1, "pre_hold");
      tick();
    end
    set_req(4, 4'b0110);
    expect_next(4, 4'b0000, 2'd1, 1'b0, "pre_bubble");
    tick();
    expect_next(4, 4'b0100, 2'd2, 1'b1, "pre_g2");
    tick();
    set_req(4, 4'b0000);
    expect_next(4, 4'b0000, 2'd2, 1'b0, "pre_end");
    tick();

    // Reset mid-grant: ptr=3 so requester 3 wins, reset clears, then 1 wins.
    set_req(4, 4'b1010);
    expect_next(4, 4'b1000, 2'd3, 1'b1, "rst_g3");
    tick();
    reset = 1'b1;
    expect_next(4, 4'b0000, 2'd0, 1'b0, "rst_clear");
    tick();
    reset = 1'b0;
    expect_next(4, 4'b0010, 2'd1, 1'b1, "rst_g1");
    tick();
    set_req(4, 4'b0000);
    expect_next(4, 4'b0000, 2'd1, 1'b0, "rst_end");
    tick();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
